// File: rtl/fdiv_sqrt_issue_ctrl.sv
// Issue/response controller for the recoded single-precision divide/sqrt unit:
// one tagged op in flight, kill handling, watchdog timeout and sticky flag accrual.
module fdiv_sqrt_issue_ctrl #(
  parameter int TAG_W       = 5,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_sqrt,
  input  logic [32:0]      req_a,
  input  logic [32:0]      req_b,
  input  logic [2:0]       req_rm,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             kill,
  input  logic             unit_inReady,
  output logic             unit_inValid,
  output logic             unit_sqrtOp,
  output logic [32:0]      unit_a,
  output logic [32:0]      unit_b,
  output logic [2:0]       unit_rm,
  input  logic             unit_outValid_div,
  input  logic             unit_outValid_sqrt,
  input  logic [32:0]      unit_out,
  input  logic [4:0]       unit_exc,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [32:0]      resp_data,
  output logic [4:0]       resp_exc,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_sqrt,
  output logic [4:0]       fflags,
  input  logic             fflags_clr,
  output logic             busy,
  output logic             proto_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  localparam logic [32:0]      REC_QNAN = 33'h0E0400000;
  localparam logic [4:0]       EXC_NV   = 5'b10000;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t             r_state;
  state_t             w_next;
  logic               r_sqrt;
  logic [32:0]        r_a;
  logic [32:0]        r_b;
  logic [2:0]         r_rm;
  logic [TAG_W-1:0]   r_tag;
  logic [CNT_W-1:0]   r_cnt;
  logic [32:0]        r_resp_data;
  logic [4:0]         r_resp_exc;
  logic [4:0]         r_fflags;
  logic               r_proto_err;

  logic w_match;
  logic w_wrong;
  logic w_any_strobe;
  logic w_timeout;
  logic w_latch;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_cap_unit;
  logic w_cap_nan;
  logic w_accrue;
  logic w_proto;

  // The expected completion strobe is selected by the latched op kind, not the live request.
  assign w_match      = r_sqrt ? unit_outValid_sqrt : unit_outValid_div;
  assign w_wrong      = r_sqrt ? unit_outValid_div  : unit_outValid_sqrt;
  assign w_any_strobe = unit_outValid_div | unit_outValid_sqrt;
  assign w_timeout    = (r_cnt >= CNT_LAST);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next     = r_state;
    w_latch    = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_cap_unit = 1'b0;
    w_cap_nan  = 1'b0;
    w_accrue   = 1'b0;
    w_proto    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_proto = w_any_strobe;
        if (req_valid) begin
          w_latch = 1'b1;
          w_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_proto = w_any_strobe;
        if (unit_inReady) begin
          // Once the unit has accepted the op, a kill can only drain it.
          w_cnt_clr = 1'b1;
          w_next    = kill ? S_DRAIN : S_WAIT;
        end else if (kill) begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        w_proto   = w_wrong;
        w_cnt_inc = 1'b1;
        if (w_match) begin
          w_cap_unit = ~kill;
          w_next     = kill ? S_IDLE : S_RESP;
        end else if (kill) begin
          w_next = S_DRAIN;
        end else if (w_timeout) begin
          w_cap_nan = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_DRAIN: begin
        w_proto   = w_wrong;
        w_cnt_inc = 1'b1;
        if (w_match || w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_RESP: begin
        w_proto = w_any_strobe;
        if (kill) begin
          w_next = S_IDLE;
        end else if (resp_ready) begin
          w_accrue = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every datapath register is reset, so outputs are defined immediately on reset assertion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sqrt      <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_rm        <= '0;
      r_tag       <= '0;
      r_cnt       <= '0;
      r_resp_data <= '0;
      r_resp_exc  <= '0;
      r_fflags    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_latch) begin
        r_sqrt <= req_sqrt;
        r_a    <= req_a;
        r_b    <= req_b;
        r_rm   <= req_rm;
        r_tag  <= req_tag;
      end

      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_cap_unit) begin
        r_resp_data <= unit_out;
        r_resp_exc  <= unit_exc;
      end else if (w_cap_nan) begin
        r_resp_data <= REC_QNAN;
        r_resp_exc  <= EXC_NV;
      end

      // A clear coinciding with a handshake leaves exactly the new flags.
      if (w_accrue) begin
        r_fflags <= (fflags_clr ? 5'b0 : r_fflags) | r_resp_exc;
      end else if (fflags_clr) begin
        r_fflags <= '0;
      end

      if (w_proto) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign unit_inValid = (r_state == S_ISSUE);
  assign unit_sqrtOp  = r_sqrt;
  assign unit_a       = r_a;
  assign unit_b       = r_b;
  assign unit_rm      = r_rm;
  assign resp_valid   = (r_state == S_RESP);
  assign resp_data    = r_resp_data;
  assign resp_exc     = r_resp_exc;
  assign resp_tag     = r_tag;
  assign resp_sqrt    = r_sqrt;
  assign fflags       = r_fflags;
  assign busy         = (r_state != S_IDLE);
  assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_fdiv_sqrt_issue_ctrl.sv
// Self-checking bench for fdiv_sqrt_issue_ctrl: transaction-level model of issue,
// completion, kill, timeout and flag accrual, driven with directed and random ops.
module tb_fdiv_sqrt_issue_ctrl;

  localparam int          TAG_W   = 5;
  localparam int          TO      = 64;
  localparam logic [32:0] REC_NAN = 33'h0E0400000;
  localparam logic [32:0] REC_1P5 = 33'h080400000;
  localparam logic [32:0] REC_0P5 = 33'h07F800000;
  localparam logic [32:0] REC_3P0 = 33'h080C00000;
  localparam logic [123:0] RST_VEC = {1'b1, 123'd0};

  logic             clock = 1'b0;
  logic             reset;
  logic             req_valid, req_ready, req_sqrt;
  logic [32:0]      req_a, req_b;
  logic [2:0]       req_rm;
  logic [TAG_W-1:0] req_tag;
  logic             kill;
  logic             unit_inReady, unit_inValid, unit_sqrtOp;
  logic [32:0]      unit_a, unit_b;
  logic [2:0]       unit_rm;
  logic             unit_outValid_div, unit_outValid_sqrt;
  logic [32:0]      unit_out;
  logic [4:0]       unit_exc;
  logic             resp_valid, resp_ready;
  logic [32:0]      resp_data;
  logic [4:0]       resp_exc;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_sqrt;
  logic [4:0]       fflags;
  logic             fflags_clr, busy, proto_err;
  logic [123:0]     obs;

  int         n_vec;
  int         n_err;
  logic [4:0] m_fflags;
  logic       m_proto;

  fdiv_sqrt_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT_CYC(TO), .CNT_W(7)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_sqrt(req_sqrt),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .req_tag(req_tag),
    .kill(kill),
    .unit_inReady(unit_inReady), .unit_inValid(unit_inValid), .unit_sqrtOp(unit_sqrtOp),
    .unit_a(unit_a), .unit_b(unit_b), .unit_rm(unit_rm),
    .unit_outValid_div(unit_outValid_div), .unit_outValid_sqrt(unit_outValid_sqrt),
    .unit_out(unit_out), .unit_exc(unit_exc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_exc(resp_exc), .resp_tag(resp_tag), .resp_sqrt(resp_sqrt),
    .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy), .proto_err(proto_err)
  );

  assign obs = {req_ready, unit_inValid, unit_sqrtOp, unit_a, unit_b, unit_rm, resp_valid,
                resp_data, resp_exc, resp_tag, resp_sqrt, fflags, busy, proto_err};

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    req_valid = 0; req_sqrt = 0; req_a = '0; req_b = '0; req_rm = '0; req_tag = '0;
    kill = 0; unit_inReady = 0; unit_outValid_div = 0; unit_outValid_sqrt = 0;
    unit_out = '0; unit_exc = '0; resp_ready = 0; fflags_clr = 0;
  endtask

  task automatic apply_reset();
    drive_idle();
    reset = 1'b0;
    m_fflags = '0;
    m_proto = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  // Offers one request, holds the unit side off for 'stall' cycles, then accepts.
  task automatic issue_op(input logic s, input logic [32:0] a, input logic [32:0] b,
                          input logic [2:0] rm, input logic [TAG_W-1:0] tag,
                          input int stall, input logic kill_hs);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL issue_req_ready: got %b want 1", req_ready);
    end
    req_valid = 1; req_sqrt = s; req_a = a; req_b = b; req_rm = rm; req_tag = tag;
    unit_inReady = 0;
    tick();
    req_valid = 0; req_sqrt = ~s; req_a = {1'b0, $urandom()}; req_b = {1'b0, $urandom()};
    req_rm = 3'($urandom()); req_tag = TAG_W'($urandom());
    for (int i = 0; i <= stall; i++) begin
      n_vec++;
      if ({unit_inValid, req_ready, unit_sqrtOp, unit_a, unit_b, unit_rm} !== {2'b10, s, a, b, rm}) begin
        n_err++;
        $display("FAIL issue_hold[%0d]: got v=%b rdy=%b s=%b a=%h b=%h rm=%h want v=1 rdy=0 s=%b a=%h b=%h rm=%h",
                 i, unit_inValid, req_ready, unit_sqrtOp, unit_a, unit_b, unit_rm, s, a, b, rm);
      end
      if (i < stall) tick();
    end
    kill = kill_hs; unit_inReady = 1;
    tick();
    kill = 0; unit_inReady = 0;
    n_vec++;
    if ({unit_inValid, busy} !== 2'b01) begin
      n_err++; $display("FAIL issue_accept: got inValid=%b busy=%b want 0 1", unit_inValid, busy);
    end
  endtask

  // Model: a matching strobe d cycles into WAIT (d < TO) returns its data one cycle later;
  // no strobe within TO cycles returns the canonical NaN with NV.
  task automatic wait_resp(input logic s, input logic [TAG_W-1:0] tag, input int d,
                           input logic [32:0] out, input logic [4:0] exc, input int wrong_at,
                           input int hold, input logic clr_hs, input logic kill_resp);
    int          lat;
    logic [32:0] e_data;
    logic [4:0]  e_exc;
    lat    = (d < TO) ? d + 1 : TO;
    e_data = (d < TO) ? out : REC_NAN;
    e_exc  = (d < TO) ? exc : 5'b10000;
    for (int i = 0; i < lat; i++) begin
      unit_out = {1'b0, $urandom()}; unit_exc = 5'($urandom());
      if (i == d) begin
        unit_out = out; unit_exc = exc;
        if (s) unit_outValid_sqrt = 1; else unit_outValid_div = 1;
      end
      if (i == wrong_at) begin
        if (s) unit_outValid_div = 1; else unit_outValid_sqrt = 1;
        m_proto = 1'b1;
      end
      tick();
      unit_outValid_div = 0; unit_outValid_sqrt = 0;
      if (i < lat - 1) begin
        n_vec++;
        if ({resp_valid, busy, proto_err} !== {2'b01, m_proto}) begin
          n_err++;
          $display("FAIL wait[%0d]: got valid=%b busy=%b perr=%b want 0 1 %b",
                   i, resp_valid, busy, proto_err, m_proto);
        end
      end
    end
    for (int h = 0; h <= hold; h++) begin
      n_vec++;
      if ({resp_valid, resp_data, resp_exc, resp_tag, resp_sqrt, proto_err} !==
          {1'b1, e_data, e_exc, tag, s, m_proto}) begin
        n_err++;
        $display("FAIL resp[%0d]: got v=%b d=%h e=%b t=%0d s=%b perr=%b want v=1 d=%h e=%b t=%0d s=%b perr=%b",
                 h, resp_valid, resp_data, resp_exc, resp_tag, resp_sqrt, proto_err,
                 e_data, e_exc, tag, s, m_proto);
      end
      unit_out = {1'b0, $urandom()}; unit_exc = 5'($urandom());
      if (h < hold) tick();
    end
    if (kill_resp) begin
      kill = 1; resp_ready = 1'($urandom());
    end else begin
      resp_ready = 1; fflags_clr = clr_hs;
    end
    tick();
    kill = 0; resp_ready = 0; fflags_clr = 0;
    if (!kill_resp) m_fflags = (clr_hs ? 5'b0 : m_fflags) | e_exc;
    n_vec++;
    if ({resp_valid, busy, req_ready, fflags} !== {3'b001, m_fflags}) begin
      n_err++;
      $display("FAIL resp_done: got v=%b busy=%b rdy=%b ff=%b want 0 0 1 %b",
               resp_valid, busy, req_ready, fflags, m_fflags);
    end
  endtask

  task automatic run_op(input logic s, input logic [32:0] a, input logic [32:0] b,
                        input logic [2:0] rm, input logic [TAG_W-1:0] tag, input int stall,
                        input int d, input logic [32:0] out, input logic [4:0] exc,
                        input int wrong_at, input int hold, input logic clr_hs, input logic kill_resp);
    issue_op(s, a, b, rm, tag, stall, 1'b0);
    wait_resp(s, tag, d, out, exc, wrong_at, hold, clr_hs, kill_resp);
  endtask

  // Model: after a kill the op ends silently at its matching strobe, or when the
  // watchdog has seen TO cycles since acceptance; no response either way.
  task automatic wait_drain(input logic s, input int kc, input int sc);
    int last;
    last = (sc >= 0 && sc < TO) ? sc + 1 : TO;
    for (int i = 0; i < last; i++) begin
      unit_out = {1'b0, $urandom()}; unit_exc = 5'($urandom());
      if (i == kc) kill = 1;
      if (i == sc) begin
        if (s) unit_outValid_sqrt = 1; else unit_outValid_div = 1;
      end
      tick();
      kill = 0; unit_outValid_div = 0; unit_outValid_sqrt = 0;
      n_vec++;
      if ({resp_valid, busy} !== {1'b0, 1'(i < last - 1)}) begin
        n_err++;
        $display("FAIL drain[%0d]: got valid=%b busy=%b want 0 %b", i, resp_valid, busy, i < last - 1);
      end
    end
    n_vec++;
    if ({req_ready, fflags, proto_err} !== {1'b1, m_fflags, m_proto}) begin
      n_err++;
      $display("FAIL drain_end: got rdy=%b ff=%b perr=%b want 1 %b %b", req_ready, fflags, proto_err, m_fflags, m_proto);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    m_fflags = '0; m_proto = 1'b0;
    n_vec++;
    if (obs !== RST_VEC) begin
      n_err++; $display("FAIL reset_state: got %h want %h", obs, RST_VEC);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
    n_vec++;
    if (obs !== RST_VEC) begin
      n_err++; $display("FAIL reset_release: got %h want %h", obs, RST_VEC);
    end
  endtask

  task automatic test_idle_strobe();
    unit_outValid_div = 1;
    tick();
    unit_outValid_div = 0;
    n_vec++;
    if ({proto_err, busy, req_ready} !== 3'b101) begin
      n_err++; $display("FAIL idle_strobe: got perr=%b busy=%b rdy=%b want 1 0 1", proto_err, busy, req_ready);
    end
    apply_reset();
    n_vec++;
    if (proto_err !== 1'b0) begin
      n_err++; $display("FAIL proto_clear: got %b want 0", proto_err);
    end
  endtask

  task automatic test_divide();
    run_op(1'b0, REC_1P5, REC_0P5, 3'd0, 5'd3, 0, 20, REC_3P0, 5'b00000, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_sqrt_backpressure();
    run_op(1'b1, REC_3P0, {1'b0, $urandom()}, 3'd2, 5'd7, 4, 9, REC_1P5, 5'b00001, -1, 2, 1'b0, 1'b0);
    fflags_clr = 1;
    tick();
    fflags_clr = 0;
    m_fflags = '0;
    n_vec++;
    if (fflags !== 5'b0) begin
      n_err++; $display("FAIL fflags_clr: got %b want 00000", fflags);
    end
  endtask

  task automatic test_fflags_clr_hs();
    run_op(1'b0, REC_1P5, REC_3P0, 3'd1, 5'd12, 1, 5, REC_0P5, 5'b00100, -1, 0, 1'b0, 1'b0);
    run_op(1'b1, REC_0P5, REC_0P5, 3'd4, 5'd13, 0, 3, REC_1P5, 5'b01000, -1, 1, 1'b1, 1'b0);
  endtask

  task automatic test_boundaries();
    run_op(1'b0, REC_3P0, REC_1P5, 3'd3, 5'd30, 0, 0, REC_1P5, 5'b00010, -1, 0, 1'b0, 1'b0);
    run_op(1'b1, REC_1P5, REC_1P5, 3'd0, 5'd31, 2, TO - 1, REC_3P0, 5'b00001, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_wrong_strobe();
    apply_reset();
    run_op(1'b1, REC_3P0, REC_0P5, 3'd0, 5'd9, 0, 15, REC_1P5, 5'b00000, 4, 1, 1'b0, 1'b0);
    apply_reset();
    run_op(1'b0, REC_3P0, REC_1P5, 3'd0, 5'd10, 0, 8, REC_3P0, 5'b00001, 8, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_op(1'b0, REC_1P5, REC_0P5, 3'd1, 5'd17, 0, TO, REC_3P0, 5'b00000, -1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_kill_issue();
    req_valid = 1; req_sqrt = 0; req_a = REC_1P5; req_b = REC_0P5; req_tag = 5'd4;
    tick();
    req_valid = 0; kill = 1; unit_inReady = 0;
    tick();
    kill = 0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({unit_inValid, busy, req_ready, resp_valid} !== 4'b0010) begin
        n_err++;
        $display("FAIL kill_issue[%0d]: got inV=%b busy=%b rdy=%b rv=%b want 0 0 1 0",
                 i, unit_inValid, busy, req_ready, resp_valid);
      end
      unit_inReady = 1;
      tick();
      unit_inReady = 0;
    end
    issue_op(1'b1, REC_3P0, REC_0P5, 3'd2, 5'd5, 0, 1'b1);
    wait_drain(1'b1, -1, 6);
    run_op(1'b0, REC_1P5, REC_0P5, 3'd0, 5'd6, 0, 4, REC_3P0, 5'b00000, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_kill_wait();
    int kc;
    int sc;
    issue_op(1'b0, REC_1P5, REC_0P5, 3'd0, 5'd8, 0, 1'b0);
    wait_drain(1'b0, 5, 12);
    issue_op(1'b1, REC_3P0, REC_0P5, 3'd0, 5'd9, 0, 1'b0);
    wait_drain(1'b1, 7, 7);
    issue_op(1'b0, REC_3P0, REC_1P5, 3'd0, 5'd10, 0, 1'b0);
    wait_drain(1'b0, 10, -1);
    for (int n = 0; n < 5; n++) begin
      kc = int'($urandom_range(0, 40));
      sc = ($urandom_range(0, 4) == 0) ? -1 : kc + int'($urandom_range(0, 15));
      issue_op(1'($urandom()), {1'b0, $urandom()}, {1'b0, $urandom()}, 3'($urandom()),
               TAG_W'($urandom()), int'($urandom_range(0, 2)), 1'b0);
      wait_drain(unit_sqrtOp, kc, sc);
    end
    run_op(1'b1, REC_1P5, REC_1P5, 3'd0, 5'd11, 0, 2, REC_1P5, 5'b00001, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_kill_resp();
    run_op(1'b0, REC_3P0, REC_1P5, 3'd0, 5'd14, 0, 6, REC_0P5, 5'b01110, -1, 1, 1'b0, 1'b1);
  endtask

  task automatic test_random_ops();
    logic s;
    for (int n = 0; n < 20; n++) begin
      s = 1'($urandom());
      run_op(s, {1'b0, $urandom()}, {1'b0, $urandom()}, 3'($urandom()), TAG_W'($urandom()),
             int'($urandom_range(0, 3)), int'($urandom_range(0, TO)), {1'b0, $urandom()},
             5'($urandom()), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1,
             int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
    end
  endtask

  task automatic test_async_reset();
    run_op(1'b0, REC_1P5, REC_0P5, 3'd0, 5'd2, 0, TO, REC_3P0, 5'b00000, -1, 0, 1'b0, 1'b0);
    issue_op(1'b1, REC_3P0, REC_1P5, 3'd5, 5'd21, 1, 1'b0);
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    m_fflags = '0; m_proto = 1'b0;
    n_vec++;
    if (obs !== RST_VEC) begin
      n_err++; $display("FAIL async_reset: got %h want %h", obs, RST_VEC);
    end
    drive_idle();
    @(negedge clock);
    reset = 1'b1;
    tick();
    run_op(1'b0, REC_1P5, REC_0P5, 3'd0, 5'd3, 0, 20, REC_3P0, 5'b00000, -1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_idle_strobe();
    test_divide();
    test_sqrt_backpressure();
    test_fflags_clr_hs();
    test_boundaries();
    test_wrong_strobe();
    test_timeout();
    test_kill_issue();
    test_kill_wait();
    test_kill_resp();
    test_random_ops();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/fdiv_sqrt_issue_ctrl.md
Name: fdiv_sqrt_issue_ctrl

Overview:
Initiator-side controller that drives the single-precision recoded divide/sqrt unit (inReady/inValid request, outValid_div/outValid_sqrt completion). It accepts one tagged operation at a time from the FPU pipeline, holds the operands stable until the unit accepts them, and waits for the completion strobe of the matching kind. It returns the 33-bit recoded result with its exception flags and tag, and accumulates sticky fflags. It also handles pipeline kill and a watchdog timeout.

Parameters:
TAG_W, 5, width of the pipeline destination tag
TIMEOUT_CYC, 64, maximum cycles in WAIT/DRAIN before forced completion
CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  pipeline request valid
req_ready  out  1  controller can accept a request
req_sqrt  in  1  1=sqrt(a), 0=a/b
req_a, req_b  in  33  recoded operands
req_rm  in  3  rounding mode
req_tag  in  TAG_W  destination tag
kill  in  1  flush of the in-flight operation
unit_inReady  in  1  unit accepts an operation
unit_inValid  out  1  operation offered to the unit
unit_sqrtOp  out  1  latched op kind
unit_a, unit_b  out  33  latched operands
unit_rm  out  3  latched rounding mode
unit_outValid_div, unit_outValid_sqrt  in  1  completion strobes (1-cycle)
unit_out  in  33  recoded result
unit_exc  in  5  exception flags {NV,DZ,OF,UF,NX}
resp_valid  out  1  result available
resp_ready  in  1  pipeline takes the result
resp_data  out  33  result
resp_exc  out  5  flags
resp_tag  out  TAG_W  tag of the result
resp_sqrt  out  1  op kind of the result
fflags  out  5  sticky accrued flags
fflags_clr  in  1  clear the sticky flags
busy  out  1  state != IDLE
proto_err  out  1  sticky: completion strobe of the wrong kind seen

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0 except req_ready=1. Latched operands, tag, counter, fflags and proto_err are 0.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE: req_ready=1. When req_valid=1, latch sqrt/a/b/rm/tag and go to ISSUE. kill is ignored in IDLE.
- ISSUE: unit_inValid=1, and the unit_* outputs come from the latched registers, stable until accepted. A handshake (inValid & inReady) goes to WAIT with counter=0.
- Kill in ISSUE: without a same-cycle handshake, go to IDLE and the unit never sees the op. With a same-cycle handshake, the op was accepted, so go to DRAIN.
- WAIT: counter increments each cycle. The matching strobe is outValid_sqrt if the latched sqrt=1, else outValid_div. On the matching strobe, capture unit_out/unit_exc and go to RESP.
- A non-matching strobe in WAIT or DRAIN is ignored and sets proto_err.
- Timeout in WAIT: when counter==TIMEOUT_CYC-1 with no matching strobe, go to RESP with data=33'h0E0400000 (canonical recoded NaN) and exc=5'b10000.
- kill in WAIT goes to DRAIN. A matching strobe in the same cycle as kill is discarded and the state goes to IDLE.
- DRAIN: wait for the matching strobe or timeout, then go to IDLE. No response is produced; counter continues from its WAIT value.
- RESP: resp_valid=1, with resp_* held from registers. On resp_ready, go to IDLE; req_ready returns the next cycle (no same-cycle bypass). kill in RESP drops the response and goes to IDLE, and the flags are not accrued.
- fflags: on each resp handshake, fflags |= resp_exc. fflags_clr clears it; if a clear and a handshake occur in the same cycle, the result is resp_exc.
- Latency: request to unit_inValid is 1 cycle; the matching strobe to resp_valid is 1 cycle.
- Strobes arriving in IDLE, ISSUE or RESP set proto_err and are otherwise ignored.

Test Plan:
- Divide: a=1.5, b=0.5 (recoded), rm=0, tag=3, inReady=1, strobe after 20 cycles with out=3.0, exc=0 -> resp_valid 1 cycle later, data=recoded 3.0, tag=3, fflags=0.
- Sqrt with backpressure: inReady low for 4 cycles -> unit_inValid held and operands stable; strobe with exc=5'b00001 -> resp_exc=00001, fflags=00001. Then fflags_clr asserted -> fflags=0.
- Kill in WAIT: kill at cycle 5, matching strobe at cycle 12 -> no resp_valid, busy drops the cycle after the strobe, next request accepted normally.
- Wrong strobe: sqrt op, outValid_div pulses -> proto_err=1, state stays WAIT; later outValid_sqrt -> normal response.
- Timeout: no strobe -> after 64 WAIT cycles, resp_data=33'h0E0400000, resp_exc=10000, fflags bit4 set.
- Async reset asserted mid-WAIT -> all outputs immediately 0 with req_ready=1; after release, a new request completes correctly.
